// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches from imem and loads the IF/ID register,
// parking one instruction in a skid buffer during decode stalls. `FETCH_PERF_EN adds perf counters.
module if_fetch_stage #(
  parameter int                     PC_WIDTH    = 64,
  parameter int                     INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h00000013
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ready,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   ifid_valid,
  output logic [PC_WIDTH-1:0]    ifid_pc,
  output logic [INSTR_WIDTH-1:0] ifid_instr,
  output logic                   dbg_state
`ifdef FETCH_PERF_EN
  ,
  output logic [63:0]            perf_fetched,
  output logic [63:0]            perf_bubbles
`endif
);

  typedef enum logic {RUN = 1'b0, BUFFERED = 1'b1} state_t;

  state_t                 state;
  logic [PC_WIDTH-1:0]    pc;
  logic [PC_WIDTH-1:0]    buf_pc;
  logic [INSTR_WIDTH-1:0] buf_instr;
  logic                   accept;

  // Handshake: a fetch transfers on a rising edge where imem_req && imem_ready; imem_rdata
  // belongs to imem_addr in that cycle. imem is stateless, so a request may be abandoned freely.
  assign imem_addr = pc;
  assign imem_req  = (state == RUN) && !reset;
  assign accept    = imem_req && imem_ready;
  assign dbg_state = (state == BUFFERED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      pc         <= RESET_PC;
      buf_pc     <= '0;
      buf_instr  <= NOP_INSTR;
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_instr <= NOP_INSTR;
    end else if (redirect_valid) begin
      // Flush wins over stall and over any word accepted this cycle.
      state      <= RUN;
      pc         <= {redirect_pc[PC_WIDTH-1:2], 2'b00};
      ifid_valid <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (accept) begin
            pc <= pc + PC_WIDTH'(4);
            if (stall) begin
              buf_pc    <= pc;
              buf_instr <= imem_rdata;
              state     <= BUFFERED;
            end else begin
              ifid_valid <= 1'b1;
              ifid_pc    <= pc;
              ifid_instr <= imem_rdata;
            end
          end else if (!stall) begin
            ifid_valid <= 1'b0;
          end
        end
        BUFFERED: begin
          if (!stall) begin
            ifid_valid <= 1'b1;
            ifid_pc    <= buf_pc;
            ifid_instr <= buf_instr;
            state      <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (accept && !redirect_valid) perf_fetched <= perf_fetched + 64'd1;
      if (!ifid_valid && !stall)     perf_bubbles <= perf_bubbles + 64'd1;
    end
  end
`endif

endmodule
